// File: rtl/arm_pipe_pkg.sv
// Shared pipeline types and constants for the ARM memory stage.
package arm_pipe_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned LANE_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  localparam logic [LANE_W-1:0] BYTE_LANE0 = 4'b0001;
  localparam logic [LANE_W-1:0] BYTE_LANE1 = 4'b0010;
  localparam logic [LANE_W-1:0] BYTE_LANE2 = 4'b0100;
  localparam logic [LANE_W-1:0] BYTE_LANE3 = 4'b1000;
  localparam logic [LANE_W-1:0] WORD_LANES = 4'b1111;

  // Payload carried from MEM into WB.
  typedef struct packed {
    logic              rd_we;
    logic [REG_W-1:0]  rd_num;
    logic [DATA_W-1:0] wb_data;
    logic              halted;
  } memwb_t;

  // True when exactly one byte lane is enabled.
  function automatic logic is_byte_lane(input logic [LANE_W-1:0] we);
    return (we == BYTE_LANE0) || (we == BYTE_LANE1) ||
           (we == BYTE_LANE2) || (we == BYTE_LANE3);
  endfunction

endpackage

// File: rtl/arm_mem_align.sv
// Store-data byte replication and load-data lane extraction (combinational).
module arm_mem_align
  import arm_pipe_pkg::*;
(
  input  logic [31:0] st_data_i,
  input  logic [3:0]  lane_we_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  input  logic        byte_ld_i,
  output logic [31:0] st_data_o,
  output logic [31:0] ld_data_o
);

  logic [7:0] ld_byte_c;

  // A single-lane store drives the byte onto every lane; memory picks by enable.
  always_comb begin
    st_data_o = st_data_i;
    if (is_byte_lane(lane_we_i)) begin
      st_data_o = {4{st_data_i[7:0]}};
    end
  end

  always_comb begin
    ld_byte_c = rdata_i[7:0];
    case (addr_lo_i)
      2'd0:    ld_byte_c = rdata_i[7:0];
      2'd1:    ld_byte_c = rdata_i[15:8];
      2'd2:    ld_byte_c = rdata_i[23:16];
      default: ld_byte_c = rdata_i[31:24];
    endcase
  end

  always_comb begin
    ld_data_o = rdata_i;
    if (byte_ld_i) begin
      ld_data_o = DATA_W'(ld_byte_c);
    end
  end

endmodule

// File: rtl/arm_mem_stage.sv
// ARM pipeline MEM stage: data-memory handshake, stall generation, MEM/ID
// forwarding and the MEM/WB pipeline register.
module arm_mem_stage
  import arm_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst_b,
  input  logic [31:0] EXMEM_data_result,
  input  logic [31:0] EXMEM_rd_data,
  input  logic        EXMEM_rd_we,
  input  logic        EXMEM_rd_data_sel,
  input  logic [3:0]  EXMEM_des_reg_num,
  input  logic [3:0]  EXMEM_mem_write_en,
  input  logic        EXMEM_ld_byte_or_word,
  input  logic        EXMEM_internal_halted,
  output logic        dmem_req,
  input  logic        dmem_ack,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_we,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        MEMID_rd_we,
  output logic [3:0]  MEMID_rd_num,
  output logic [31:0] MEMID_data,
  output logic        MEMWB_rd_we,
  output logic [3:0]  MEMWB_rd_num,
  output logic [31:0] MEMWB_wb_data,
  output logic        MEMWB_internal_halted
);

  mem_state_t        state_q, state_d;
  memwb_t            memwb_q, memwb_d;
  logic              access_pend_c;
  logic [DATA_W-1:0] ld_data_c;
  logic [DATA_W-1:0] wb_data_c;

  // Once a halt has reached WB nothing further may touch memory.
  assign access_pend_c = (EXMEM_rd_data_sel | (|EXMEM_mem_write_en))
                         & ~EXMEM_internal_halted & ~memwb_q.halted;

  // Gating with rst_b drops the request as soon as reset asserts.
  assign dmem_req   = access_pend_c & rst_b;
  assign mem_stall  = dmem_req & ~dmem_ack;
  assign dmem_addr  = {EXMEM_data_result[31:2], 2'b00};
  assign dmem_we    = EXMEM_mem_write_en;

  arm_mem_align u_align (
    .st_data_i (EXMEM_rd_data),
    .lane_we_i (EXMEM_mem_write_en),
    .addr_lo_i (EXMEM_data_result[1:0]),
    .rdata_i   (dmem_rdata),
    .byte_ld_i (EXMEM_ld_byte_or_word),
    .st_data_o (dmem_wdata),
    .ld_data_o (ld_data_c)
  );

  assign wb_data_c    = EXMEM_rd_data_sel ? ld_data_c : EXMEM_data_result;
  assign MEMID_rd_we  = EXMEM_rd_we & ~mem_stall;
  assign MEMID_rd_num = EXMEM_des_reg_num;
  assign MEMID_data   = wb_data_c;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (dmem_req && !dmem_ack) state_d = WAIT;
      WAIT: if (dmem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A stall inserts a bubble into WB while the rest of the payload holds.
  always_comb begin
    memwb_d = memwb_q;
    if (mem_stall) begin
      memwb_d.rd_we = 1'b0;
    end else begin
      memwb_d.rd_we   = EXMEM_rd_we;
      memwb_d.rd_num  = EXMEM_des_reg_num;
      memwb_d.wb_data = wb_data_c;
      memwb_d.halted  = memwb_q.halted | EXMEM_internal_halted;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      memwb_q <= '0;
    end else begin
      memwb_q <= memwb_d;
    end
  end

  assign MEMWB_rd_we           = memwb_q.rd_we;
  assign MEMWB_rd_num          = memwb_q.rd_num;
  assign MEMWB_wb_data         = memwb_q.wb_data;
  assign MEMWB_internal_halted = memwb_q.halted;

endmodule

// File: tb/tb_arm_mem_stage.sv
// Randomized self-checking bench for arm_mem_stage with a behavioural model.
module tb_arm_mem_stage;
  import arm_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] EXMEM_data_result, EXMEM_rd_data;
  logic        EXMEM_rd_we, EXMEM_rd_data_sel;
  logic [3:0]  EXMEM_des_reg_num, EXMEM_mem_write_en;
  logic        EXMEM_ld_byte_or_word, EXMEM_internal_halted;
  logic        dmem_req, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_we;
  logic        mem_stall;
  logic        MEMID_rd_we;
  logic [3:0]  MEMID_rd_num;
  logic [31:0] MEMID_data;
  logic        MEMWB_rd_we;
  logic [3:0]  MEMWB_rd_num;
  logic [31:0] MEMWB_wb_data;
  logic        MEMWB_internal_halted;

  int n_chk = 0;
  int n_err = 0;

  arm_mem_stage dut (
    .clk(clk), .rst_b(rst_b),
    .EXMEM_data_result(EXMEM_data_result), .EXMEM_rd_data(EXMEM_rd_data),
    .EXMEM_rd_we(EXMEM_rd_we), .EXMEM_rd_data_sel(EXMEM_rd_data_sel),
    .EXMEM_des_reg_num(EXMEM_des_reg_num), .EXMEM_mem_write_en(EXMEM_mem_write_en),
    .EXMEM_ld_byte_or_word(EXMEM_ld_byte_or_word),
    .EXMEM_internal_halted(EXMEM_internal_halted),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack), .dmem_addr(dmem_addr),
    .dmem_we(dmem_we), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall),
    .MEMID_rd_we(MEMID_rd_we), .MEMID_rd_num(MEMID_rd_num), .MEMID_data(MEMID_data),
    .MEMWB_rd_we(MEMWB_rd_we), .MEMWB_rd_num(MEMWB_rd_num),
    .MEMWB_wb_data(MEMWB_wb_data), .MEMWB_internal_halted(MEMWB_internal_halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the WB-side state: what WB must hold after each edge.
  logic        m_we, m_halt;
  logic [3:0]  m_num;
  logic [31:0] m_wb;

  function automatic logic [31:0] ref_store(input logic [3:0] en, input logic [31:0] d);
    if ($countones(en) == 1) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [31:0] a,
                                           input logic byt);
    if (!byt) return rd;
    return (rd >> (8 * int'(a[1:0]))) & 32'h0000_00FF;
  endfunction

  function automatic logic ref_req();
    return (rst_b === 1'b1) && (EXMEM_rd_data_sel || EXMEM_mem_write_en != 4'd0) &&
           !EXMEM_internal_halted && !m_halt;
  endfunction

  function automatic logic [31:0] ref_wb();
    return EXMEM_rd_data_sel ? ref_load(dmem_rdata, EXMEM_data_result, EXMEM_ld_byte_or_word)
                             : EXMEM_data_result;
  endfunction

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_we <= 1'b0; m_halt <= 1'b0; m_num <= 4'd0; m_wb <= 32'd0;
    end else if (ref_req() && !dmem_ack) begin
      m_we <= 1'b0;
    end else begin
      m_we   <= EXMEM_rd_we;
      m_num  <= EXMEM_des_reg_num;
      m_wb   <= ref_wb();
      m_halt <= m_halt | EXMEM_internal_halted;
    end
  end

  // Every cycle: compare all outputs against the model.
  always begin : cmp
    logic r, s;
    @(negedge clk);
    #2;
    r = ref_req();
    s = r && dmem_ack;
    s = r && !s;
    chk("dmem_req", 32'(dmem_req), 32'(r));
    chk("mem_stall", 32'(mem_stall), 32'(s));
    chk("dmem_addr", dmem_addr, {EXMEM_data_result[31:2], 2'b00});
    chk("dmem_we", 32'(dmem_we), 32'(EXMEM_mem_write_en));
    chk("dmem_wdata", dmem_wdata, ref_store(EXMEM_mem_write_en, EXMEM_rd_data));
    chk("memid_we", 32'(MEMID_rd_we), 32'(EXMEM_rd_we && !s));
    chk("memid_num", 32'(MEMID_rd_num), 32'(EXMEM_des_reg_num));
    chk("memid_data", MEMID_data, ref_wb());
    chk("memwb_we", 32'(MEMWB_rd_we), 32'(m_we));
    chk("memwb_num", 32'(MEMWB_rd_num), 32'(m_num));
    chk("memwb_data", MEMWB_wb_data, m_wb);
    chk("memwb_halt", 32'(MEMWB_internal_halted), 32'(m_halt));
  end

  // Present one EXMEM op; memory acks after d wait cycles. Returns at the
  // negedge following the completing edge.
  task automatic do_op(input logic [31:0] res, input logic [31:0] rdd, input logic rwe,
                       input logic sel, input logic [3:0] num, input logic [3:0] wen,
                       input logic byt, input logic halt, input int d,
                       input logic [31:0] rdv, output int stalls, output logic req0,
                       output logic [31:0] wdata0, output logic [31:0] memid0);
    logic pend;
    EXMEM_data_result = res; EXMEM_rd_data = rdd; EXMEM_rd_we = rwe;
    EXMEM_rd_data_sel = sel; EXMEM_des_reg_num = num; EXMEM_mem_write_en = wen;
    EXMEM_ld_byte_or_word = byt; EXMEM_internal_halted = halt;
    stalls = 0;
    for (int c = 0; c <= d; c++) begin
      pend = ref_req();
      dmem_ack   = pend ? (c == d) : ($urandom_range(0, 3) == 0);
      dmem_rdata = (pend && c == d) ? rdv : $urandom;
      #3;
      if (c == 0) begin
        req0 = dmem_req; wdata0 = dmem_wdata; memid0 = MEMID_data;
      end
      if (mem_stall) stalls++;
      @(negedge clk);
      if (!pend) break;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : drive
    int st;
    logic rq;
    logic [31:0] wd, md;
    rst_b = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = 32'hFFFF_FFFF;
    EXMEM_data_result = 32'h104; EXMEM_rd_data = 32'h1; EXMEM_rd_we = 1'b1;
    EXMEM_rd_data_sel = 1'b1; EXMEM_des_reg_num = 4'd2; EXMEM_mem_write_en = 4'hF;
    EXMEM_ld_byte_or_word = 1'b0; EXMEM_internal_halted = 1'b0;
    @(negedge clk);
    #3;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_wb_we", 32'(MEMWB_rd_we), 32'd0);
    chk("rst_wb_data", MEMWB_wb_data, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;

    // Word load, zero wait.
    do_op(32'h0000_0104, 32'h0, 1'b1, 1'b1, 4'd7, 4'd0, 1'b0, 1'b0, 0,
          32'hDEAD_BEEF, st, rq, wd, md);
    chk("wload_data", MEMWB_wb_data, 32'hDEAD_BEEF);
    chk("wload_we", 32'(MEMWB_rd_we), 32'd1);
    chk("wload_stalls", 32'(st), 32'd0);

    // Byte load from lane 3.
    do_op(32'h0000_0107, 32'h0, 1'b1, 1'b1, 4'd9, 4'd0, 1'b1, 1'b0, 0,
          32'h1122_3344, st, rq, wd, md);
    chk("bload_data", MEMWB_wb_data, 32'h0000_0011);

    // ALU result bypasses memory.
    do_op(32'h5, 32'h0, 1'b1, 1'b0, 4'd3, 4'd0, 1'b0, 1'b0, 0, 32'h0, st, rq, wd, md);
    chk("alu_req", 32'(rq), 32'd0);
    chk("alu_memid", md, 32'h5);
    chk("alu_wb", MEMWB_wb_data, 32'h5);
    chk("alu_num", 32'(MEMWB_rd_num), 32'd3);

    // Byte store with three wait cycles.
    do_op(32'h0000_0202, 32'h0000_00AB, 1'b0, 1'b0, 4'd1, 4'b0100, 1'b0, 1'b0, 3,
          32'h0, st, rq, wd, md);
    chk("bstore_wdata", wd, 32'hABAB_ABAB);
    chk("bstore_stalls", 32'(st), 32'd3);

    // Randomized traffic, no halts.
    for (int i = 0; i < 400; i++) begin
      int kind;
      logic [3:0] wen;
      kind = int'($urandom_range(0, 2));
      case ($urandom_range(0, 5))
        0: wen = 4'b0001;
        1: wen = 4'b0010;
        2: wen = 4'b0100;
        3: wen = 4'b1000;
        4: wen = 4'b1111;
        default: wen = 4'($urandom_range(1, 15));
      endcase
      do_op($urandom, $urandom, 1'($urandom), kind == 1, 4'($urandom),
            (kind == 2) ? wen : 4'd0, 1'($urandom), 1'b0,
            int'($urandom_range(0, 3)), $urandom, st, rq, wd, md);
    end

    // Reset asserted while waiting on memory.
    EXMEM_data_result = 32'h40; EXMEM_rd_data_sel = 1'b1; EXMEM_rd_we = 1'b1;
    EXMEM_mem_write_en = 4'd0; EXMEM_internal_halted = 1'b0; dmem_ack = 1'b0;
    EXMEM_des_reg_num = 4'd5;
    @(negedge clk);
    do_op(32'h0000_0300, 32'h0, 1'b1, 1'b0, 4'd4, 4'd0, 1'b0, 1'b0, 0, 32'h0, st, rq, wd, md);
    EXMEM_data_result = 32'h0000_0040; EXMEM_rd_data_sel = 1'b1; dmem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #3;
    chk("wait_stall_pre", 32'(mem_stall), 32'd1);
    rst_b = 1'b0;
    #1;
    chk("wrst_req", 32'(dmem_req), 32'd0);
    chk("wrst_stall", 32'(mem_stall), 32'd0);
    chk("wrst_wb_data", MEMWB_wb_data, 32'd0);
    chk("wrst_wb_num", 32'(MEMWB_rd_num), 32'd0);
    @(negedge clk);
    EXMEM_rd_data_sel = 1'b0;
    rst_b = 1'b1;
    #3;
    chk("wrst_state", 32'(dut.state_q), 32'(IDLE));

    // Halt with store enables: no request, halt sticks.
    do_op(32'h0000_0300, 32'h55, 1'b0, 1'b0, 4'd0, 4'hF, 1'b0, 1'b1, 0, 32'h0, st, rq, wd, md);
    chk("halt_req", 32'(rq), 32'd0);
    chk("halt_wb", 32'(MEMWB_internal_halted), 32'd1);
    do_op(32'h0000_0104, 32'h0, 1'b1, 1'b1, 4'd6, 4'd0, 1'b0, 1'b0, 2, 32'h1, st, rq, wd, md);
    chk("halted_req", 32'(rq), 32'd0);
    chk("halted_sticky", 32'(MEMWB_internal_halted), 32'd1);
    for (int i = 0; i < 20; i++) begin
      do_op($urandom, $urandom, 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
            1'($urandom), 1'b0, 1, $urandom, st, rq, wd, md);
    end
    chk("halted_end", 32'(MEMWB_internal_halted), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
